// File: rtl/srff_bank_arbiter.sv
// Round-robin arbitrated controller for a bank of SR flag bits (q/qbar pairs).
// Requesters send {r,s} commands on a valid/ready handshake. A command is granted in IDLE,
// then applied to the bank as the FSM leaves APPLY, so the bank accepts one command every
// two cycles.
// Optional build macro SRFF_BANK_FIXED_PRIO_EN: fixed priority, where the lowest index wins
// and there is no rotating pointer.
module srff_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  parameter int unsigned IDXW  = (NFLAG > 1) ? $clog2(NFLAG) : 1,
  localparam int unsigned GIDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_rs,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NFLAG-1:0]     q,
  output logic [NFLAG-1:0]     qbar,
  output logic [GIDW-1:0]      grant_id,
  output logic                 busy,
  input  logic                 err_clr,
  output logic                 err
);

  localparam logic [GIDW-1:0] LastId = GIDW'(NREQ - 1);

  typedef enum logic {StIdle, StApply} state_e;

  state_e           state_q, state_d;
  logic [1:0]       rs_q, rs_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [GIDW-1:0]  grant_id_q, grant_id_d;
  logic [NFLAG-1:0] q_q, q_d, qbar_q, qbar_d;
  logic             err_q, err_d;
  logic [GIDW-1:0]  rr_ptr;

  logic             hi_found, lo_found, pick_found;
  logic [GIDW-1:0]  hi_id, lo_id, pick_id;
  logic [1:0]       pick_rs;
  logic [IDXW-1:0]  pick_idx;
  logic             idx_ok;

`ifdef SRFF_BANK_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [GIDW-1:0] rr_ptr_q, rr_ptr_d;

  // Pointer advances past the requester just served, when its command retires.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == StApply) begin
      rr_ptr_d = (grant_id_q == LastId) ? '0 : grant_id_q + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`endif

  // Pick the first valid requester at or above rr_ptr, else wrap to the lowest one below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        if (GIDW'(k) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_id    = GIDW'(k);
        end else begin
          lo_found = 1'b1;
          lo_id    = GIDW'(k);
        end
      end
    end
    pick_found = hi_found | lo_found;
    pick_id    = hi_found ? hi_id : lo_id;
  end

  // Mux out the winner's command fields.
  always_comb begin
    pick_rs  = '0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (GIDW'(k) == pick_id) begin
        pick_rs  = req_rs[2*k +: 2];
        pick_idx = req_idx[IDXW*k +: IDXW];
      end
    end
  end

  assign idx_ok = (32'(idx_q) < NFLAG);

  // FSM next state: latch at grant, apply to the bank and flag errors on APPLY exit.
  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    idx_d      = idx_q;
    grant_id_d = grant_id_q;
    q_d        = q_q;
    qbar_d     = qbar_q;
    err_d      = err_q;
    if (err_clr) err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d    = StApply;
          rs_d       = pick_rs;
          idx_d      = pick_idx;
          grant_id_d = pick_id;
        end
      end
      StApply: begin
        state_d = StIdle;
        if (!idx_ok) begin
          err_d = 1'b1;
        end else begin
          for (int f = 0; f < NFLAG; f++) begin
            if (IDXW'(f) == idx_q) begin
              case (rs_q)
                2'b01: begin q_d[f] = 1'b1; qbar_d[f] = 1'b0; end
                2'b10: begin q_d[f] = 1'b0; qbar_d[f] = 1'b1; end
                2'b11: begin q_d[f] = 1'b1; qbar_d[f] = 1'b1; end
                default: ;
              endcase
            end
          end
          // Forbidden {1,1}; set beats a coincident err_clr.
          if (rs_q == 2'b11) err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and bank registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rs_q       <= '0;
      idx_q      <= '0;
      grant_id_q <= '0;
      q_q        <= '0;
      qbar_q     <= '1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      idx_q      <= idx_d;
      grant_id_q <= grant_id_d;
      q_q        <= q_d;
      qbar_q     <= qbar_d;
      err_q      <= err_d;
    end
  end

  // Ready is decoded from state so an asynchronous reset drops it at once.
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_ready[k] = (state_q == StApply) && (grant_id_q == GIDW'(k));
    end
  end

  assign busy     = (state_q == StApply);
  assign q        = q_q;
  assign qbar     = qbar_q;
  assign grant_id = grant_id_q;
  assign err      = err_q;

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Scoreboard bench for srff_bank_arbiter (NREQ=4, NFLAG=8).
// Expected grants are queued by the stimulus; a monitor pops one per ready pulse.
module tb_srff_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_rs = '0;
  logic [11:0] req_idx = '0;
  logic [3:0]  req_ready;
  logic [7:0]  q, qbar;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_clr = 1'b0;
  logic        err;

  srff_bank_arbiter #(.NREQ(4), .NFLAG(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .q         (q),
    .qbar      (qbar),
    .grant_id  (grant_id),
    .busy      (busy),
    .err_clr   (err_clr),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned gid;
    logic [7:0]  q;
    logic [7:0]  qbar;
    logic        err;
    bit          gap;  // expect exactly 2 cycles since previous grant
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   mon_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input int unsigned g, input logic [7:0] eq, input logic [7:0] eqb,
                      input logic ee, input bit gap);
    exp_t e;
    e.gid = g; e.q = eq; e.qbar = eqb; e.err = ee; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int k, input logic [1:0] rs, input logic [2:0] idx);
    req_rs[2*k +: 2]  = rs;
    req_idx[3*k +: 3] = idx;
    req_valid[k]      = 1'b1;
  endtask

  // Requester side: each drops valid just after the edge that completes its handshake.
  task automatic serve(input int budget);
    logic [3:0] ack;
    int n;
    n = 0;
    while (req_valid != 0 && n < budget) begin
      @(negedge clk);
      ack = req_ready & req_valid;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~ack;
      n++;
    end
    if (req_valid != 0) begin
      tests++;
      fails++;
      $display("FAIL serve_timeout: pending valid %0h after %0d cycles", req_valid, budget);
      req_valid = '0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || mon_busy) begin
      fails++;
      $display("FAIL drain: %0d expected grants never seen", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: on each ready pulse check the grant, then the bank one edge later.
  initial begin
    exp_t e;
    int   last_cyc;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n && req_ready != 0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_grant: ready %0h expected none", req_ready);
        end else begin
          mon_busy = 1'b1;
          e = exp_q.pop_front();
          chk("ready_onehot", 32'(req_ready), 32'(4'b1 << e.gid));
          chk("grant_id", 32'(grant_id), e.gid);
          chk("busy", 32'(busy), 1);
          if (e.gap) chk("grant_gap", cyc - last_cyc, 2);
          last_cyc = cyc;
          @(negedge clk);
          chk("q", 32'(q), 32'(e.q));
          chk("qbar", 32'(qbar), 32'(e.qbar));
          chk("err", 32'(err), 32'(e.err));
          chk("ready_drop", 32'(req_ready), 0);
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_qbar", 32'(qbar), 32'hFF);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_q", 32'(q), 32'h00);
    chk("idle_busy", 32'(busy), 0);

    // Single set then clear on flag 3
    push(0, 8'h08, 8'hF7, 1'b0, 1'b0);
    set_req(0, 2'b01, 3'd3);
    serve(10); drain();
    push(0, 8'h00, 8'hFF, 1'b0, 1'b0);
    set_req(0, 2'b10, 3'd3);
    serve(10); drain();

    // Fresh reset so the pointer starts at 0, then a full set wave and a clear wave
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    push(0, 8'h01, 8'hFE, 1'b0, 1'b0);
    push(1, 8'h03, 8'hFC, 1'b0, 1'b1);
    push(2, 8'h07, 8'hF8, 1'b0, 1'b1);
    push(3, 8'h0F, 8'hF0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) set_req(k, 2'b01, 3'(k));
    serve(20); drain();
    push(0, 8'h0E, 8'hF1, 1'b0, 1'b0);
    push(1, 8'h0C, 8'hF3, 1'b0, 1'b1);
    push(2, 8'h08, 8'hF7, 1'b0, 1'b1);
    push(3, 8'h00, 8'hFF, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) set_req(k, 2'b10, 3'(k));
    serve(20); drain();

    // Set flag 2, then a hold command on it
    push(2, 8'h04, 8'hFB, 1'b0, 1'b0);
    set_req(2, 2'b01, 3'd2);
    serve(10); drain();
    push(2, 8'h04, 8'hFB, 1'b0, 1'b0);
    set_req(2, 2'b00, 3'd2);
    serve(10); drain();

    // Requesters 0 and 3 together, rotating pointer now at 3
`ifdef SRFF_BANK_FIXED_PRIO_EN
    push(0, 8'h44, 8'hBB, 1'b0, 1'b0);
    push(3, 8'hC4, 8'h3B, 1'b0, 1'b1);
`else
    push(3, 8'h84, 8'h7B, 1'b0, 1'b0);
    push(0, 8'hC4, 8'h3B, 1'b0, 1'b1);
`endif
    set_req(0, 2'b01, 3'd6);
    set_req(3, 2'b01, 3'd7);
    serve(20); drain();

    // Forbidden command sets err; err_clr clears it
    push(2, 8'hE4, 8'h3B, 1'b1, 1'b0);
    set_req(2, 2'b11, 3'd5);
    serve(10); drain();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_cleared", 32'(err), 0);
    push(2, 8'hE4, 8'h3B, 1'b1, 1'b0);
    set_req(2, 2'b11, 3'd5);
    serve(10); drain();
    // err_clr held across a new forbidden command: set wins at APPLY exit
    @(negedge clk);
    err_clr = 1'b1;
    push(2, 8'hE6, 8'h3B, 1'b1, 1'b0);
    set_req(2, 2'b11, 3'd1);
    serve(10);
    err_clr = 1'b0;
    drain();

    // Reset during APPLY discards the command and drops ready immediately
    @(negedge clk);
    set_req(0, 2'b01, 3'd3);
    @(posedge clk); #3;
    chk("apply_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(req_ready), 0);
    chk("rst_mid_q", 32'(q), 32'h00);
    chk("rst_mid_qbar", 32'(qbar), 32'hFF);
    chk("rst_mid_err", 32'(err), 0);
    set_req(1, 2'b01, 3'd7);
    push(0, 8'h08, 8'hF7, 1'b0, 1'b0);
    push(1, 8'h88, 8'h77, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    serve(20); drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
